// File: rtl/active_transfer_fifo.sv
// Generic show-ahead FIFO: power-of-two depth with an occupancy count.
// Latency: a pushed word appears at rd_dat one cycle after the push edge.
// Backpressure: wr_rdy is low when full. A push while full is still accepted if a pop happens in the same cycle.
module fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  uc_clk,
  input  logic                  uc_reset,
  input  logic                  wr_vld,
  output logic                  wr_rdy,
  input  logic [DATA_W-1:0]     wr_dat,
  output logic                  rd_vld,
  input  logic                  rd_rdy,
  output logic [DATA_W-1:0]     rd_dat,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_fire;
  logic                  rd_fire;

  assign rd_vld  = (count != '0);
  assign wr_rdy  = (count != CW'(DEPTH));
  assign rd_fire = rd_vld & rd_rdy;
  // A pop frees a slot this cycle, so a push into a full FIFO can ride along.
  assign wr_fire = wr_vld & (wr_rdy | rd_fire);
  assign rd_dat  = mem[rd_ptr];

  // Storage array: no reset, because occupancy alone decides which entries are meaningful.
  always_ff @(posedge uc_clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap modulo the depth. The count only moves when exactly one side fires.
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (rd_fire) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Per-channel bus endpoint: queues TRANSFER_IN words into RX and drains TX as TRANSFER_OUT with a busy handshake.
// Latency: an RX word is on rx_data 1 cycle after the command match; a TX word is on uc_out 1 cycle after the FSM leaves idle.
// Backpressure: RX drops a word and flags rx_overflow when full with no pop; tx_ready is low while TX is full.
module active_transfer_fifo #(
  parameter int              DATA_W       = 8,
  parameter int              ADDR_W       = 3,
  parameter int              CMD_W        = 3,
  parameter int              LEN_W        = 8,
  parameter int              DEPTH_LOG2   = 4,
  parameter logic [CMD_W-1:0] IN_CMD      = 3'd1,
  parameter logic [CMD_W-1:0] OUT_CMD     = 3'd2,
  parameter int              HOLD_CYCLES  = 3,
  parameter int              BUSY_TIMEOUT = 255
) (
  input  logic                  uc_clk,
  input  logic                  uc_reset,
  input  logic [ADDR_W-1:0]     chan_addr,
  input  logic [ADDR_W-1:0]     uc_in_addr,
  input  logic [CMD_W-1:0]      uc_in_cmd,
  input  logic [DATA_W-1:0]     uc_in_data,
  input  logic                  uc_in_busy,
  output logic [DATA_W-1:0]     uc_out_data,
  output logic [CMD_W-1:0]      uc_out_cmd,
  output logic [ADDR_W-1:0]     uc_out_addr,
  output logic [LEN_W-1:0]      uc_out_length,
  output logic [DATA_W-1:0]     rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DEPTH_LOG2:0]   rx_count,
  input  logic [DATA_W-1:0]     tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic                  transfer_busy,
  output logic                  rx_overflow,
  output logic                  tx_timeout,
  input  logic                  clear_errors
);
  // One counter serves both the hold window and the busy timeout, so size it for the larger of the two.
  localparam int CNT_MAX = (HOLD_CYCLES > BUSY_TIMEOUT) ? HOLD_CYCLES : BUSY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {RX_IDLE, RX_HOLD} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_DRIVE, TX_WAIT_HI, TX_WAIT_LO} tx_state_t;

  rx_state_t        rx_state;
  rx_state_t        rx_state_nxt;
  tx_state_t        tx_state;
  tx_state_t        tx_state_nxt;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] tx_cnt_nxt;

  logic              in_match;
  logic              rx_push;
  logic              rx_not_full;
  logic              rx_pop;
  logic              tx_pop;
  logic              tx_push;
  logic              tx_nonempty;
  logic [DATA_W-1:0] tx_head;
  logic              timeout_set;

  assign in_match      = (uc_in_addr == chan_addr) && (uc_in_cmd == IN_CMD);
  assign rx_pop        = rx_valid & rx_ready;
  assign tx_push       = tx_valid & tx_ready;
  assign transfer_busy = (tx_state != TX_IDLE);
  assign uc_out_length = '0;

  fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .uc_clk   (uc_clk),
    .uc_reset (uc_reset),
    .wr_vld   (rx_push),
    .wr_rdy   (rx_not_full),
    .wr_dat   (uc_in_data),
    .rd_vld   (rx_valid),
    .rd_rdy   (rx_ready),
    .rd_dat   (rx_data),
    .count    (rx_count)
  );

  fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .uc_clk   (uc_clk),
    .uc_reset (uc_reset),
    .wr_vld   (tx_push),
    .wr_rdy   (tx_ready),
    .wr_dat   (tx_data),
    .rd_vld   (tx_nonempty),
    .rd_rdy   (tx_pop),
    .rd_dat   (tx_head),
    .count    (tx_count)
  );

  // RX state register.
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) rx_state <= RX_IDLE;
    else           rx_state <= rx_state_nxt;
  end

  // RX next state: push once when a matching command first appears, then hold until the match drops.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_push      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (in_match) begin
          rx_push      = 1'b1;
          rx_state_nxt = RX_HOLD;
        end
      end
      RX_HOLD: begin
        if (!in_match) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX overflow flag: sticky, and clear_errors takes priority over a new drop.
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset)                             rx_overflow <= 1'b0;
    else if (clear_errors)                     rx_overflow <= 1'b0;
    else if (rx_push && !rx_not_full && !rx_pop) rx_overflow <= 1'b1;
  end

  // TX state and phase counter registers.
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
    end
  end

  // TX next state: drive the head for the hold window, pop it, then handshake on host busy with a timeout.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt + CNT_W'(1);
    tx_pop       = 1'b0;
    timeout_set  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_nxt = '0;
        if (tx_nonempty && !uc_in_busy) tx_state_nxt = TX_DRIVE;
      end
      TX_DRIVE: begin
        if (tx_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          tx_pop       = 1'b1;
          tx_cnt_nxt   = '0;
          tx_state_nxt = TX_WAIT_HI;
        end
      end
      TX_WAIT_HI: begin
        if (uc_in_busy) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = TX_WAIT_LO;
        end else if (tx_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_set  = 1'b1;
          tx_cnt_nxt   = '0;
          tx_state_nxt = TX_IDLE;
        end
      end
      TX_WAIT_LO: begin
        tx_cnt_nxt = '0;
        if (!uc_in_busy) tx_state_nxt = TX_IDLE;
      end
      default: begin
        tx_cnt_nxt   = '0;
        tx_state_nxt = TX_IDLE;
      end
    endcase
  end

  // Bus output fields: loaded from the next state so that they line up with TX_DRIVE, and zero otherwise.
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      uc_out_data <= '0;
      uc_out_cmd  <= '0;
      uc_out_addr <= '0;
    end else if (tx_state_nxt == TX_DRIVE) begin
      uc_out_data <= tx_head;
      uc_out_cmd  <= OUT_CMD;
      uc_out_addr <= chan_addr;
    end else begin
      uc_out_data <= '0;
      uc_out_cmd  <= '0;
      uc_out_addr <= '0;
    end
  end

  // TX timeout flag: sticky, and clear_errors takes priority over a new timeout.
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset)         tx_timeout <= 1'b0;
    else if (clear_errors) tx_timeout <= 1'b0;
    else if (timeout_set)  tx_timeout <= 1'b1;
  end
endmodule
